pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipelined successor to the single-cycle control decoder. Decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. Generates load-use stalls, branch-taken flushes and an optional multi-cycle MUL hold. It sits between the IF/ID register and the datapath stage registers of the pipelined CPU.

## Interface
- OPC_W, 4, opcode width
- ALUOP_W, 3, ALU operation width
- RA_W, 3, register-address width
- MUL_CYCLES, 3, EX occupancy of MUL when multi-cycle (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; all state cleared on assertion, released synchronously to clk
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  OPC_W  opcode in ID
- id_rs, id_rt, id_rd  in  RA_W each  ID register fields
- ex_branch_taken  in  1  BEQ in EX resolved taken (ALU zero & ex_branch)
- stall  out  1  hold PC and IF/ID (combinational)
- flush  out  1  clear IF/ID (combinational)
- ex_aluop  out  ALUOP_W;  ex_alu_src, ex_branch  out  1
- mem_write, mem_read  out  1  EX/MEM-stage memory controls
- wb_wen, wb_mem_to_reg  out  1;  wb_dest  out  RA_W
- illegal_op  out  1  registered; opcode in EX was undefined

## Operation
- Encoding: ADD 0, SUB 1, AND 2, XOR 3, SLL 4, SRL 5, COM 6, MUL 7, LW 8, SW 9, BEQ 10; 11–15 undefined.
- Decode:
  - ALU ops: wen=1, aluop=opcode[2:0], dest=rd.
  - SLL/SRL/LW/SW: alu_src=1.
  - LW: aluop=ADD, mem_read=1, mem_to_reg=1, wen=1, dest=rt.
  - SW: aluop=ADD, mem_write=1.
  - BEQ: aluop=SUB, branch=1.
  - Undefined or id_valid=0: bubble (all controls 0); an undefined opcode with id_valid=1 additionally sets the illegal bit.
- Load-use hazard:
  - Condition: ID/EX holds LW with dest≠0 and dest equal to id_rs, or to id_rt when the ID op reads rt (ALU ops other than SLL/SRL, SW, BEQ), with id_valid=1.
  - Response: stall=1, bubble into ID/EX, EX/MEM advances.
- Branch: ex_branch_taken=1 → flush=1; ID/EX loads a bubble next edge. flush beats stall; stall is forced 0 in that cycle.
- Illegal: illegal_op=1 while EX holds an undefined opcode. It is a pure flag; the instruction behaves as a bubble.
- Pipeline registers: EX/MEM and MEM/WB copy the previous stage each cycle unless a hold applies.

## Timing
- Reset: every stage register is a bubble. All outputs are 0, wb_dest=0, MUL counter=0.
- Decode-to-ex_* latency is 1 cycle; ex_* to mem_* is 1; mem_* to wb_* is 1.
- stall and flush are combinational from the current stage registers and ID inputs, valid within the same cycle.
- Load-use stall lasts exactly 1 cycle: the LW moves to EX/MEM, so the hazard clears.
- MUL hold (macro on):
  - Counter loads MUL_CYCLES-1 when MUL enters EX.
  - While the counter is nonzero: stall=1, ID/EX holds, EX/MEM receives a bubble, counter decrements.
  - MUL leaves EX on the cycle after the counter reaches 0.
  - Counter never wraps: it saturates at 0.
- Simultaneous events:
  - Load-use with MUL busy: MUL hold wins.
  - Branch taken with MUL busy: cannot occur, because EX holds the MUL, not a BEQ.
- Reset mid-hold: counter and all stages clear immediately; stall=0.

## Configuration
- PIPE_CTRL_MUL_MC_EN defined: MUL occupies EX for MUL_CYCLES cycles using the down-counter and hold described above.
- Undefined: MUL is single-cycle like the other ALU ops. The counter logic is absent and MUL never raises stall.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode localparams (OP_ADD…OP_BEQ);
  - a packed struct ctrl_t {wen, aluop, alu_src, branch, mem_read, mem_write, mem_to_reg, illegal, dest};
  - the constant CTRL_BUBBLE (all zero).
- Sub-module pipe_ctrl_dec is the purely combinational opcode→ctrl_t decoder. Hazard logic, the counter and the stage registers live in pipe_ctrl.

## Test plan
- Reset with rst_n low mid-stream → all outputs 0 on the same cycle; first ADD after release shows ex_aluop=0, ex_* asserted 1 cycle later, wb_wen=1 3 cycles after decode.
- LW r2 then ADD using r2 as rs → stall=1 for exactly 1 cycle, one bubble (wb_wen=0) between LW and ADD at WB. LW r0 then the same ADD → no stall.
- BEQ with ex_branch_taken=1 while LW-hazard instruction is in ID → flush=1, stall=0, ID/EX bubble next cycle.
- Opcode 13 with id_valid=1 → illegal_op=1 for 1 cycle, mem_write/wb_wen stay 0.
- With PIPE_CTRL_MUL_MC_EN and MUL_CYCLES=3: MUL followed by ADD → stall high 2 cycles, 2 bubbles reach EX/MEM, ADD reaches EX 3 cycles after MUL. Without the macro → no stall.
- SW followed by BEQ → mem_write=1 for one cycle, wb_wen=0 for both, ex_alu_src=1 then 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, control bundle and helpers for the pipelined control decoder.
package pipe_ctrl_pkg;

  localparam int CTRL_OPC_W   = 4;
  localparam int CTRL_ALUOP_W = 3;
  localparam int CTRL_RA_W    = 3;

  localparam logic [CTRL_OPC_W-1:0] OP_ADD = 4'd0;
  localparam logic [CTRL_OPC_W-1:0] OP_SUB = 4'd1;
  localparam logic [CTRL_OPC_W-1:0] OP_AND = 4'd2;
  localparam logic [CTRL_OPC_W-1:0] OP_XOR = 4'd3;
  localparam logic [CTRL_OPC_W-1:0] OP_SLL = 4'd4;
  localparam logic [CTRL_OPC_W-1:0] OP_SRL = 4'd5;
  localparam logic [CTRL_OPC_W-1:0] OP_COM = 4'd6;
  localparam logic [CTRL_OPC_W-1:0] OP_MUL = 4'd7;
  localparam logic [CTRL_OPC_W-1:0] OP_LW  = 4'd8;
  localparam logic [CTRL_OPC_W-1:0] OP_SW  = 4'd9;
  localparam logic [CTRL_OPC_W-1:0] OP_BEQ = 4'd10;

  localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SUB = 3'd1;

  typedef struct packed {
    logic                    wen;
    logic [CTRL_ALUOP_W-1:0] aluop;
    logic                    alu_src;
    logic                    branch;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    illegal;
    logic [CTRL_RA_W-1:0]    dest;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Ops whose rt field is a source operand (shifts use it as an immediate).
  function automatic logic reads_rt(input logic [CTRL_OPC_W-1:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL, OP_SW, OP_BEQ: reads_rt = 1'b1;
      default:                                                      reads_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_dec.sv
// Purely combinational opcode -> control bundle decoder for the ID stage.
module pipe_ctrl_dec
  import pipe_ctrl_pkg::*;
(
  input  logic                  valid,
  input  logic [CTRL_OPC_W-1:0] opcode,
  input  logic [CTRL_RA_W-1:0]  rt,
  input  logic [CTRL_RA_W-1:0]  rd,
  output ctrl_t                 ctrl
);

  always_comb begin
    ctrl = CTRL_BUBBLE;
    if (valid) begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_COM, OP_MUL: begin
          ctrl.wen     = 1'b1;
          ctrl.aluop   = opcode[CTRL_ALUOP_W-1:0];
          ctrl.dest    = rd;
          ctrl.alu_src = (opcode == OP_SLL) || (opcode == OP_SRL);
        end
        OP_LW: begin
          ctrl.aluop      = ALU_ADD;
          ctrl.alu_src    = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.wen        = 1'b1;
          ctrl.dest       = rt;
        end
        OP_SW: begin
          ctrl.aluop     = ALU_ADD;
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        OP_BEQ: begin
          ctrl.aluop  = ALU_SUB;
          ctrl.branch = 1'b1;
        end
        // Undefined opcodes travel as a bubble that only carries the flag.
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control: ID decode, ID/EX, EX/MEM, MEM/WB registers, load-use stall, branch flush.
// PIPE_CTRL_MUL_MC_EN makes MUL hold EX for MUL_CYCLES cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OPC_W      = 4,
  parameter int ALUOP_W    = 3,
  parameter int RA_W       = 3,
  parameter int MUL_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OPC_W-1:0]   id_opcode,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               ex_branch_taken,
  output logic               stall,
  output logic               flush,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               mem_write,
  output logic               mem_read,
  output logic               wb_wen,
  output logic               wb_mem_to_reg,
  output logic [RA_W-1:0]    wb_dest,
  output logic               illegal_op
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  ctrl_t id_ctrl;
  ctrl_t idex;
  ctrl_t exmem;
  ctrl_t memwb;
  logic  load_use;
  logic  mul_busy;
  logic [CNT_W-1:0] mul_cnt;

  pipe_ctrl_dec u_dec (
    .valid  (id_valid),
    .opcode (id_opcode),
    .rt     (id_rt),
    .rd     (id_rd),
    .ctrl   (id_ctrl)
  );

  assign load_use = id_valid && idex.mem_read && (idex.dest != '0) &&
                    ((idex.dest == id_rs) || (reads_rt(id_opcode) && (idex.dest == id_rt)));

  // A taken branch squashes IF/ID, so any hazard on that instruction is moot.
  assign flush = ex_branch_taken;
  assign stall = !ex_branch_taken && (mul_busy || load_use);

`ifdef PIPE_CTRL_MUL_MC_EN
  logic mul_enter;

  assign mul_enter = id_valid && (id_opcode == OP_MUL) && !flush && !stall;
  assign mul_busy  = (mul_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt <= '0;
    end else if (mul_busy) begin
      mul_cnt <= mul_cnt - CNT_W'(1);
    end else if (mul_enter) begin
      mul_cnt <= CNT_W'(MUL_CYCLES - 1);
    end
  end
`else
  assign mul_cnt  = '0;
  assign mul_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex  <= CTRL_BUBBLE;
      exmem <= CTRL_BUBBLE;
      memwb <= CTRL_BUBBLE;
    end else begin
      if (mul_busy) begin
        // MUL keeps EX; downstream sees bubbles until it completes.
        exmem <= CTRL_BUBBLE;
      end else begin
        idex  <= (flush || stall) ? CTRL_BUBBLE : id_ctrl;
        exmem <= idex;
      end
      memwb <= exmem;
    end
  end

  assign ex_aluop      = idex.aluop;
  assign ex_alu_src    = idex.alu_src;
  assign ex_branch     = idex.branch;
  assign illegal_op    = idex.illegal;
  assign mem_write     = exmem.mem_write;
  assign mem_read      = exmem.mem_read;
  assign wb_wen        = memwb.wen;
  assign wb_mem_to_reg = memwb.mem_to_reg;
  assign wb_dest       = memwb.dest;

  logic unused_memwb;
  assign unused_memwb = ^memwb;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-stage expectations queued at issue, checked on arrival.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic       wen;
    logic       m2r;
    logic [2:0] dest;
    logic       mr;
    logic       mw;
    logic       ill;
    logic       br;
    logic       src;
    logic [2:0] aluop;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       ex_branch_taken;
  logic       stall, flush;
  logic [2:0] ex_aluop;
  logic       ex_alu_src, ex_branch;
  logic       mem_write, mem_read;
  logic       wb_wen, wb_mem_to_reg;
  logic [2:0] wb_dest;
  logic       illegal_op;

  logic [25:0] exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [14:0] all_outs;
  logic [3:0]  r_op;
  logic [2:0]  r_rs, r_rt, r_rd;

  pipe_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .ex_aluop        (ex_aluop),
    .ex_alu_src      (ex_alu_src),
    .ex_branch       (ex_branch),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .wb_wen          (wb_wen),
    .wb_mem_to_reg   (wb_mem_to_reg),
    .wb_dest         (wb_dest),
    .illegal_op      (illegal_op)
  );

  assign all_outs = {stall, flush, ex_aluop, ex_alu_src, ex_branch, mem_write, mem_read,
                     wb_wen, wb_mem_to_reg, wb_dest, illegal_op};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected control bundle straight from the opcode table.
  function automatic exp_t dec(input logic [3:0] op, input logic [2:0] rt, input logic [2:0] rd);
    exp_t e;
    e = '0;
    case (op)
      4'd0: begin e.wen = 1; e.aluop = 3'd0; e.dest = rd; end
      4'd1: begin e.wen = 1; e.aluop = 3'd1; e.dest = rd; end
      4'd2: begin e.wen = 1; e.aluop = 3'd2; e.dest = rd; end
      4'd3: begin e.wen = 1; e.aluop = 3'd3; e.dest = rd; end
      4'd4: begin e.wen = 1; e.aluop = 3'd4; e.dest = rd; e.src = 1; end
      4'd5: begin e.wen = 1; e.aluop = 3'd5; e.dest = rd; e.src = 1; end
      4'd6: begin e.wen = 1; e.aluop = 3'd6; e.dest = rd; end
      4'd7: begin e.wen = 1; e.aluop = 3'd7; e.dest = rd; end
      4'd8: begin e.wen = 1; e.m2r = 1; e.mr = 1; e.src = 1; e.dest = rt; end
      4'd9: begin e.mw = 1; e.src = 1; end
      4'd10: begin e.br = 1; e.aluop = 3'd1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic [25:0] mk(input logic [1:0] k, input int c, input logic [7:0] d);
    return {k, c[15:0], d};
  endfunction

  // ---------------- drivers ----------------
  // One ID cycle: drive, check combinational stall/flush, queue what each stage must show.
  task automatic cycle_in(input logic v, input logic [3:0] op, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [2:0] rd, input logic tk,
                          input logic exp_stall, input logic exp_flush,
                          input exp_t ex_e, input exp_t mw_e);
    @(posedge clk);
    #1;
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = tk;
    #1;
    check($sformatf("stall@%0d", cyc), stall, exp_stall);
    check($sformatf("flush@%0d", cyc), flush, exp_flush);
    exp_q.push_back(mk(2'd0, cyc + 1, {2'b00, ex_e.ill, ex_e.br, ex_e.src, ex_e.aluop}));
    exp_q.push_back(mk(2'd1, cyc + 2, {6'b0, mw_e.mr, mw_e.mw}));
    exp_q.push_back(mk(2'd2, cyc + 3, {3'b0, mw_e.wen, mw_e.m2r, mw_e.dest}));
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [2:0] rd, input logic tk,
                      input logic exp_stall, input logic exp_flush);
    exp_t e;
    e = (v && !exp_stall && !exp_flush) ? dec(op, rt, rd) : exp_t'('0);
    cycle_in(v, op, rs, rt, rd, tk, exp_stall, exp_flush, e, e);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    int i;
    logic [25:0] e;
    logic [7:0] got;
    string tag;
    i = 0;
    while (i < exp_q.size()) begin
      e = exp_q[i];
      if (e[23:8] == cyc[15:0]) begin
        case (e[25:24])
          2'd0:    begin got = {2'b00, illegal_op, ex_branch, ex_alu_src, ex_aluop}; tag = "ex"; end
          2'd1:    begin got = {6'b0, mem_read, mem_write}; tag = "mem"; end
          default: begin got = {3'b0, wb_wen, wb_mem_to_reg, wb_dest}; tag = "wb"; end
        endcase
        check($sformatf("%s@%0d", tag, cyc), got, e[7:0]);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0; ex_branch_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs, 15'd0);
    rst_n = 1'b1;

    // first instruction after reset, then random ALU traffic
    step(1, OP_ADD, 3'd1, 3'd2, 3'd1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      r_op = 4'($urandom_range(0, 6));
      r_rs = 3'($urandom_range(0, 7));
      r_rt = 3'($urandom_range(0, 7));
      r_rd = 3'($urandom_range(1, 7));
      step(1, r_op, r_rs, r_rt, r_rd, 0, 0, 0);
    end

    // load-use on rs: one stall, then the ADD issues
    step(1, OP_LW,  3'd1, 3'd2, 3'd0, 0, 0, 0);
    step(1, OP_ADD, 3'd2, 3'd3, 3'd4, 0, 1, 0);
    step(1, OP_ADD, 3'd2, 3'd3, 3'd4, 0, 0, 0);
    // LW to r0 never stalls
    step(1, OP_LW,  3'd1, 3'd0, 3'd0, 0, 0, 0);
    step(1, OP_ADD, 3'd0, 3'd0, 3'd5, 0, 0, 0);
    // rt hazard only for ops that read rt
    step(1, OP_LW,  3'd1, 3'd3, 3'd0, 0, 0, 0);
    step(1, OP_SUB, 3'd1, 3'd3, 3'd6, 0, 1, 0);
    step(1, OP_SUB, 3'd1, 3'd3, 3'd6, 0, 0, 0);
    step(1, OP_LW,  3'd1, 3'd4, 3'd0, 0, 0, 0);
    step(1, OP_SLL, 3'd1, 3'd4, 3'd7, 0, 0, 0);

    // branch flush, and flush overriding a load-use stall
    step(1, OP_BEQ, 3'd1, 3'd2, 3'd0, 0, 0, 0);
    step(1, OP_LW,  3'd1, 3'd5, 3'd0, 1, 0, 1);
    step(1, OP_LW,  3'd1, 3'd2, 3'd0, 0, 0, 0);
    step(1, OP_ADD, 3'd2, 3'd1, 3'd3, 1, 0, 1);
    step(1, OP_ADD, 3'd2, 3'd1, 3'd3, 0, 0, 0);

    // illegal opcode flags only when valid
    step(1, 4'd13, 3'd1, 3'd2, 3'd3, 0, 0, 0);
    step(0, 4'd14, 3'd1, 3'd2, 3'd3, 0, 0, 0);
    step(1, 4'd15, 3'd0, 3'd0, 3'd0, 0, 0, 0);

    // store then branch
    step(1, OP_SW,  3'd1, 3'd2, 3'd5, 0, 0, 0);
    step(1, OP_BEQ, 3'd1, 3'd2, 3'd5, 0, 0, 0);

    // MUL followed by a dependent ADD
`ifdef PIPE_CTRL_MUL_MC_EN
    cycle_in(1, OP_MUL, 3'd1, 3'd2, 3'd7, 0, 0, 0, dec(OP_MUL, 3'd2, 3'd7), exp_t'('0));
    cycle_in(1, OP_ADD, 3'd7, 3'd1, 3'd2, 0, 1, 0, dec(OP_MUL, 3'd2, 3'd7), exp_t'('0));
    cycle_in(1, OP_ADD, 3'd7, 3'd1, 3'd2, 0, 1, 0, dec(OP_MUL, 3'd2, 3'd7), dec(OP_MUL, 3'd2, 3'd7));
    step(1, OP_ADD, 3'd7, 3'd1, 3'd2, 0, 0, 0);
`else
    step(1, OP_MUL, 3'd1, 3'd2, 3'd7, 0, 0, 0);
    step(1, OP_ADD, 3'd7, 3'd1, 3'd2, 0, 0, 0);
`endif

    // reset mid-stream with a hazard pending in ID
    step(1, OP_LW, 3'd1, 3'd6, 3'd0, 0, 0, 0);
    step(1, OP_ADD, 3'd1, 3'd2, 3'd3, 0, 0, 0);
    @(posedge clk);
    #1;
    id_valid = 1; id_opcode = OP_ADD; id_rs = 3'd3; id_rt = 3'd6; id_rd = 3'd1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("reset_mid", all_outs, 15'd0);
    @(posedge clk);
    #1;
    check("reset_hold", all_outs, 15'd0);
    rst_n = 1'b1;
    id_valid = 0;

    step(1, OP_ADD, 3'd1, 3'd2, 3'd3, 0, 0, 0);
    step(1, OP_LW,  3'd0, 3'd5, 3'd0, 0, 0, 0);
    repeat (3) step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 0, 0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
